// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-port arbiter: requester indices,
// requester count, FSM state encoding and a one-hot to index helper.
package cpu_mem_pkg;

  localparam int NREQ     = 3;
  localparam int IDX_W    = 2;
  localparam int REQ_IF   = 0;
  localparam int REQ_DATA = 1;
  localparam int REQ_EXT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index of the set bit in a one-hot requester vector (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory-port arbiter.
// Build option ARB_ROUND_ROBIN_EN: rotating priority starting one after
// ptr (the last granted index). Otherwise fixed priority 2 > 1 > 0 and
// the ptr port does not exist.
module arb_pick
  import cpu_mem_pkg::*;
(
  input  logic [NREQ-1:0]  req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  winner
);

`ifdef ARB_ROUND_ROBIN_EN
  // Scan from ptr+1 around the ring; the first active request wins.
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  // Fixed priority: boot/debug port first, then data, then fetch.
  always_comb begin
    winner = '0;
    if (req[REQ_EXT])       winner[REQ_EXT]  = 1'b1;
    else if (req[REQ_DATA]) winner[REQ_DATA] = 1'b1;
    else if (req[REQ_IF])   winner[REQ_IF]   = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch, data and the
// external boot/debug port. One access at a time: IDLE -> BUSY (MEM_LAT
// cycles, mem_en in the first) -> DONE (one-cycle ack) -> IDLE.
// Build option ARB_ROUND_ROBIN_EN selects rotating priority with a pointer
// register updated on DONE; without it priority is fixed 2 > 1 > 0.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | no access; arbitrate any pending request at the next edge
//  ST_BUSY | memory access in flight, cnt counts MEM_LAT-1 down to 0
//  ST_DONE | ack to winner for one cycle, grant still held
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             we_q;
  logic [NREQ-1:0]  winner;
  logic [IDX_W-1:0] win_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  arb_pick u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  // Pointer remembers the last granted requester; it moves once per access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  rr_ptr <= '0;
    else if (state == ST_DONE)  rr_ptr <= onehot_to_idx(gnt);
  end
`else
  arb_pick u_pick (
    .req    (req),
    .winner (winner)
  );
`endif

  assign win_idx = onehot_to_idx(winner);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req)       state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == '0)  state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Access datapath: latch the winner's request, pulse mem_en, capture read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      cnt       <= '0;
      we_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= winner;
            cnt       <= CW'(MEM_LAT - 1);
            we_q      <= |(req_we & winner);
            mem_en    <= 1'b1;
            mem_we    <= |(req_we & winner);
            mem_addr  <= req_addr[int'(win_idx)*AW +: AW];
            mem_wdata <= req_wdata[int'(win_idx)*DW +: DW];
          end
        end
        ST_BUSY: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (cnt != '0)  cnt   <= cnt - 1'b1;
          else if (!we_q) rdata <= mem_rdata;
        end
        ST_DONE: begin
          gnt <= '0;
        end
        default: begin
          gnt    <= '0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign ack  = (state == ST_DONE) ? gnt : '0;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=2 instance with a
// sync-read memory model and one MEM_LAT=1 instance with an async-read model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MEM_LAT = 2 instance
  logic [2:0]      req, req_we, gnt, ack;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            busy, mem_en, mem_we;

  // MEM_LAT = 1 instance
  logic [2:0]      l1_req, l1_req_we, l1_gnt, l1_ack;
  logic [3*AW-1:0] l1_req_addr;
  logic [3*DW-1:0] l1_req_wdata;
  logic [DW-1:0]   l1_rdata, l1_mem_wdata, l1_mem_rdata;
  logic [AW-1:0]   l1_mem_addr;
  logic            l1_busy, l1_mem_en, l1_mem_we;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) dut (
    .clk(clk), .reset(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(rst), .req(l1_req), .req_we(l1_req_we), .req_addr(l1_req_addr),
    .req_wdata(l1_req_wdata), .gnt(l1_gnt), .ack(l1_ack), .rdata(l1_rdata), .busy(l1_busy),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata)
  );

  // Sync-read memory: fixed pattern, 0x10 holds 0xDEADBEEF, remembers the last write.
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wr_valid <= 1'b1;
        wr_addr  <= mem_addr;
        wr_data  <= mem_wdata;
      end else if (wr_valid && mem_addr == wr_addr) begin
        mem_rdata <= wr_data;
      end else if (mem_addr == 32'h10) begin
        mem_rdata <= 32'hDEAD_BEEF;
      end else begin
        mem_rdata <= 32'h5000_0000 ^ mem_addr;
      end
    end
  end

  // Async-read memory for the single-cycle instance.
  assign l1_mem_rdata = 32'h1000_0000 ^ l1_mem_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps until mem_en is seen (start of an access) and returns the grant.
  task automatic wait_grant(output logic [2:0] g);
    g = 3'b000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_en) begin
        g = gnt;
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL grant_timeout: observed no mem_en expected a grant within 8 cycles");
  endtask

  logic [2:0]  g;
  logic [2:0]  exp_seq [4];
  logic [31:0] cur_addr;
  logic        seen;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b001; exp_seq[3] = 3'b010;
`else
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b100; exp_seq[2] = 3'b100; exp_seq[3] = 3'b100;
`endif
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    l1_req = '0; l1_req_we = '0; l1_req_addr = '0; l1_req_wdata = '0;
    step(); step();
    check("rst_gnt",    32'(gnt),    0);
    check("rst_ack",    32'(ack),    0);
    check("rst_busy",   32'(busy),   0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_rdata",  rdata,       0);
    check("rst_maddr",  mem_addr,    0);
    rst = 1'b0;
    step();

    // 1: single read from requester 0
    req = 3'b001; req_addr = {32'h0, 32'h0, 32'h10};
    step();
    check("t1_mem_en", 32'(mem_en), 1);
    check("t1_maddr",  mem_addr,    32'h10);
    check("t1_mem_we", 32'(mem_we), 0);
    check("t1_gnt",    32'(gnt),    32'b001);
    check("t1_busy",   32'(busy),   1);
    step();
    check("t1_en_drop", 32'(mem_en), 0);
    check("t1_ack_early", 32'(ack), 0);
    step();
    check("t1_ack",   32'(ack), 32'b001);
    check("t1_rdata", rdata,    32'hDEAD_BEEF);
    req = 3'b000;
    step();
    check("t1_ack_pulse", 32'(ack),  0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_gnt",  32'(gnt),  0);

    // 2: write from requester 1, then read it back from requester 2
    req = 3'b010; req_we = 3'b010;
    req_addr = {32'h0, 32'h20, 32'h0}; req_wdata = {32'h0, 32'h1234, 32'h0};
    step();
    check("t2_mem_en", 32'(mem_en), 1);
    check("t2_mem_we", 32'(mem_we), 1);
    check("t2_wdata",  mem_wdata,   32'h1234);
    check("t2_maddr",  mem_addr,    32'h20);
    check("t2_gnt",    32'(gnt),    32'b010);
    step();
    check("t2_we_drop", 32'(mem_we), 0);
    step();
    check("t2_ack",   32'(ack), 32'b010);
    check("t2_rdata", rdata,    32'hDEAD_BEEF);
    req = 3'b000; req_we = 3'b000;
    step();
    req = 3'b100; req_addr = {32'h20, 32'h0, 32'h0};
    step();
    check("t2_rb_gnt", 32'(gnt), 32'b100);
    step(); step();
    check("t2_rb_ack",   32'(ack), 32'b100);
    check("t2_rb_rdata", rdata,    32'h1234);
    req = 3'b000;
    step();

    // 3: contention after reset, all three requesting
    rst = 1'b1; step(); rst = 1'b0; step();
    req = 3'b111; req_addr = {32'h8, 32'h4, 32'h0};
    for (int n = 0; n < 4; n++) begin
      wait_grant(g);
      check($sformatf("t3_grant%0d", n), 32'(g), 32'(exp_seq[n]));
    end
    req = 3'b000;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (ack != 3'b000) seen = 1'b1;
    end
    check("t3_drop_ack", 32'(ack), 32'(exp_seq[3]));
    step();

    // 4: requester 0 arrives while requester 1 is busy
    req = 3'b010; req_addr = {32'h0, 32'h24, 32'h30};
    step();
    check("t4_gnt1", 32'(gnt), 32'b010);
    req = 3'b011;
    step(); step();
    check("t4_ack1",   32'(ack), 32'b010);
    check("t4_rdata1", rdata,    32'h5000_0024);
    req = 3'b001;
    step();
    check("t4_idle_gnt",  32'(gnt),  0);
    check("t4_idle_busy", 32'(busy), 0);
    step();
    check("t4_gnt0",   32'(gnt),    32'b001);
    check("t4_maddr0", mem_addr,    32'h30);
    check("t4_en0",    32'(mem_en), 1);
    step(); step();
    check("t4_ack0",   32'(ack), 32'b001);
    check("t4_rdata0", rdata,    32'h5000_0030);
    req = 3'b000;
    step();

    // 5: reset in cycle 2 of an access
    req = 3'b001; req_addr = {32'h0, 32'h0, 32'h10};
    step();
    check("t5_busy_pre", 32'(busy), 1);
    step();
    rst = 1'b1;
    #1;
    check("t5_en",    32'(mem_en), 0);
    check("t5_gnt",   32'(gnt),    0);
    check("t5_busy",  32'(busy),   0);
    check("t5_ack",   32'(ack),    0);
    check("t5_maddr", mem_addr,    0);
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_ack_rst", 32'(ack), 0);
    end
    rst = 1'b0;
    step();
    check("t5_no_ack_after", 32'(ack), 0);
    req = 3'b100; req_addr = {32'h8, 32'h0, 32'h0};
    step();
    check("t5_fresh_gnt", 32'(gnt), 32'b100);
    step(); step();
    check("t5_fresh_ack",   32'(ack), 32'b100);
    check("t5_fresh_rdata", rdata,    32'h5000_0008);
    req = 3'b000;
    step();

    // 6: MEM_LAT=1, back-to-back reads from requester 0
    cur_addr = 32'h40;
    l1_req = 3'b001; l1_req_addr = {32'h0, 32'h0, cur_addr};
    for (int t = 0; t < 9; t++) begin
      step();
      if (t % 3 == 1) begin
        check($sformatf("t6_ack%0d", t), 32'(l1_ack), 32'b001);
        check($sformatf("t6_rdata%0d", t), l1_rdata, 32'h1000_0000 ^ cur_addr);
        cur_addr = cur_addr + 32'h4;
        l1_req_addr = {32'h0, 32'h0, cur_addr};
      end else begin
        check($sformatf("t6_noack%0d", t), 32'(l1_ack), 0);
        if (t % 3 == 0) check($sformatf("t6_en%0d", t), 32'(l1_mem_en), 1);
      end
    end
    l1_req = 3'b000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
